// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and Gray/binary conversions for the async FIFO
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int ADDR_W = 8;
   localparam int PTR_W  = ADDR_W + 1;

   // Conversions work on 32-bit values so any pointer width up to 32 can reuse them.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin = gray;
      for (int i = 1; i < 32; i++) begin
         bin = bin ^ (gray >> i);
      end
      return bin;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
// ============================================================================
// Module      : fifo_wptr_full_if
// Description : Write-side control bundle between producer and write-pointer stage
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wptr_full_if #(
   parameter int ADDR_W = fifo_pkg::ADDR_W
);
   localparam int PTR_W = ADDR_W + 1;

   logic              w_en;
   logic [PTR_W-1:0]  r_gray_ptr;
   logic [ADDR_W-1:0] w_addr;
   logic [PTR_W-1:0]  w_gray_ptr;
   logic              w_full;
   logic              w_almost_full;
   logic [PTR_W-1:0]  w_level;
   logic              w_overflow;

   modport master (
      output w_en,
      output r_gray_ptr,
      input  w_addr,
      input  w_gray_ptr,
      input  w_full,
      input  w_almost_full,
      input  w_level,
      input  w_overflow
   );

   modport slave (
      input  w_en,
      input  r_gray_ptr,
      output w_addr,
      output w_gray_ptr,
      output w_full,
      output w_almost_full,
      output w_level,
      output w_overflow
   );

endinterface

`default_nettype wire

// File: rtl/sync_2ff_bus.sv
// ============================================================================
// Module      : sync_2ff_bus
// Description : Two-flop bus synchroniser; input must be Gray-coded or otherwise stable
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff_bus #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // First stage samples the foreign-domain bus directly, with no logic in front.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/fifo_wptr_full.sv
// ============================================================================
// Module      : fifo_wptr_full
// Description : Write-domain pointer, full/almost-full, level and overflow status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wptr_full #(
   parameter int ADDR_W       = fifo_pkg::ADDR_W,
   parameter int AFULL_THRESH = 240
) (
   input  logic                   w_clk,
   input  logic                   w_rst_n,
   fifo_wptr_full_if.slave        bus
);
   import fifo_pkg::*;

   localparam int C_PTR_W = ADDR_W + 1;

   logic [C_PTR_W-1:0] r_bin;
   logic [C_PTR_W-1:0] r_gray;
   logic [C_PTR_W-1:0] r_level;
   logic               r_full;
   logic               r_almost_full;
   logic               r_overflow;

   logic               w_accept;
   logic [C_PTR_W-1:0] w_bin_next;
   logic [C_PTR_W-1:0] w_gray_next;
   logic [C_PTR_W-1:0] w_rq2;
   logic [C_PTR_W-1:0] w_r_bin_s;
   logic [C_PTR_W-1:0] w_level_next;
   logic               w_full_next;
   logic               w_almost_full_next;

   sync_2ff_bus #(
      .WIDTH (C_PTR_W)
   ) u_rgray_sync (
      .clk   (w_clk),
      .rst_n (w_rst_n),
      .d     (bus.r_gray_ptr),
      .q     (w_rq2)
   );

   assign w_accept     = bus.w_en & ~r_full;
   assign w_bin_next   = r_bin + C_PTR_W'(w_accept);
   assign w_gray_next  = C_PTR_W'(bin2gray(32'(w_bin_next)));
   assign w_r_bin_s    = C_PTR_W'(gray2bin(32'(w_rq2)));
   assign w_level_next = w_bin_next - w_r_bin_s;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign w_full_next = (w_gray_next ==
                         {~w_rq2[C_PTR_W-1:C_PTR_W-2], w_rq2[C_PTR_W-3:0]});
   assign w_almost_full_next = (int'(w_level_next) >= AFULL_THRESH);

   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         r_bin         <= '0;
         r_gray        <= '0;
         r_level       <= '0;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_bin         <= w_bin_next;
         r_gray        <= w_gray_next;
         r_level       <= w_level_next;
         r_full        <= w_full_next;
         r_almost_full <= w_almost_full_next;
         r_overflow    <= bus.w_en & r_full;
      end
   end

   assign bus.w_addr        = r_bin[ADDR_W-1:0];
   assign bus.w_gray_ptr    = r_gray;
   assign bus.w_full        = r_full;
   assign bus.w_almost_full = r_almost_full;
   assign bus.w_level       = r_level;
   assign bus.w_overflow    = r_overflow;

endmodule

`default_nettype wire
